// File: rtl/memory_stage.sv
// Memory-access stage: doubleword data memory, branch resolution and the MEM/WB register.
// After reset a clear state machine zero-fills the memory before instructions are accepted.
module memory_stage #(
  parameter int DEPTH = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        valid_in,
  input  logic [63:0] ALU_result,
  input  logic [63:0] Write_data,
  input  logic [63:0] Target,
  input  logic        Zero,
  input  logic        Branch,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic        MemtoReg,
  input  logic        RegWrite,
  input  logic [4:0]  rd,
  output logic        ready,
  output logic        PCSrc,
  output logic [63:0] Branch_target,
  output logic        wb_valid,
  output logic        wb_RegWrite,
  output logic [4:0]  wb_rd,
  output logic [63:0] wb_data,
  output logic        mem_error
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  state_t          state_r;
  state_t          state_nxt_s;
  logic [AW-1:0]   clr_idx_r;
  logic            clr_we_s;
  logic [63:0]     mem_r [0:DEPTH-1];

  logic            acc_s;
  logic            bad_s;
  logic            store_s;
  logic [AW-1:0]   idx_s;
  logic [63:0]     rd_data_s;
  logic [63:0]     wb_data_s;

  // state register and clear-address counter
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= ST_CLEAR;
      clr_idx_r <= {AW{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      if (clr_we_s) begin
        clr_idx_r <= clr_idx_r + AW'(1);
      end
    end
  end

  // next-state logic: leave CLEAR once the last word has been zeroed
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_CLEAR: begin
        if (clr_idx_r == LAST_IDX) begin
          state_nxt_s = ST_RUN;
        end else begin
          state_nxt_s = ST_CLEAR;
        end
      end
      ST_RUN:  state_nxt_s = ST_RUN;
      default: state_nxt_s = ST_CLEAR;
    endcase
  end

  // FSM outputs
  always_comb begin
    ready    = 1'b0;
    clr_we_s = 1'b0;
    case (state_r)
      ST_CLEAR: clr_we_s = 1'b1;
      ST_RUN:   ready    = 1'b1;
      default: begin
        ready    = 1'b0;
        clr_we_s = 1'b0;
      end
    endcase
  end

  // address decode, access qualification and write-back value selection
  always_comb begin
    acc_s     = valid_in & ready;
    idx_s     = ALU_result[AW+2:3];
    bad_s     = (MemRead | MemWrite) &
                ((ALU_result[2:0] != 3'b000) || (ALU_result[63:AW+3] != {(64-AW-3){1'b0}}));
    store_s   = acc_s & MemWrite & ~bad_s;
    rd_data_s = mem_r[idx_s];
    if (bad_s) begin
      wb_data_s = 64'd0;
    end else if (MemtoReg) begin
      wb_data_s = rd_data_s;
    end else begin
      wb_data_s = ALU_result;
    end
  end

  // data memory write port; the clear sweep owns the port until RUN
  always_ff @(posedge clk) begin
    if (clr_we_s) begin
      mem_r[clr_idx_r] <= 64'd0;
    end else if (store_s) begin
      mem_r[idx_s] <= Write_data;
    end
  end

  // MEM/WB pipeline register
  always_ff @(posedge clk) begin
    if (reset) begin
      wb_valid    <= 1'b0;
      wb_RegWrite <= 1'b0;
      wb_rd       <= 5'd0;
      wb_data     <= 64'd0;
      mem_error   <= 1'b0;
    end else if (ready) begin
      wb_valid    <= acc_s;
      wb_RegWrite <= acc_s & RegWrite & ~bad_s;
      wb_rd       <= rd;
      wb_data     <= wb_data_s;
      mem_error   <= acc_s & bad_s;
    end else begin
      wb_valid    <= 1'b0;
      wb_RegWrite <= 1'b0;
      wb_rd       <= 5'd0;
      wb_data     <= 64'd0;
      mem_error   <= 1'b0;
    end
  end

  assign PCSrc         = acc_s & Branch & Zero;
  assign Branch_target = Target;

endmodule

// File: tb/tb_memory_stage.sv
// Self-checking bench for memory_stage: a reference memory model feeds a scoreboard queue
// of expected MEM/WB bundles that are compared one cycle after each instruction is driven.
module tb_memory_stage;

  localparam int DEPTH = 256;
  localparam int AW    = $clog2(DEPTH);

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        valid_in = 1'b0;
  logic [63:0] ALU_result = 64'd0;
  logic [63:0] Write_data = 64'd0;
  logic [63:0] Target = 64'd0;
  logic        Zero = 1'b0;
  logic        Branch = 1'b0;
  logic        MemRead = 1'b0;
  logic        MemWrite = 1'b0;
  logic        MemtoReg = 1'b0;
  logic        RegWrite = 1'b0;
  logic [4:0]  rd = 5'd0;
  logic        ready;
  logic        PCSrc;
  logic [63:0] Branch_target;
  logic        wb_valid;
  logic        wb_RegWrite;
  logic [4:0]  wb_rd;
  logic [63:0] wb_data;
  logic        mem_error;

  typedef struct packed {
    logic        v;
    logic        rw;
    logic [4:0]  rd;
    logic [63:0] data;
    logic        err;
  } wb_t;

  wb_t         sb_q[$];
  logic [63:0] model_mem [0:DEPTH-1];
  int          checks = 0;
  int          errors = 0;

  memory_stage #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .valid_in(valid_in), .ALU_result(ALU_result),
    .Write_data(Write_data), .Target(Target), .Zero(Zero), .Branch(Branch),
    .MemRead(MemRead), .MemWrite(MemWrite), .MemtoReg(MemtoReg), .RegWrite(RegWrite),
    .rd(rd), .ready(ready), .PCSrc(PCSrc), .Branch_target(Branch_target),
    .wb_valid(wb_valid), .wb_RegWrite(wb_RegWrite), .wb_rd(wb_rd), .wb_data(wb_data),
    .mem_error(mem_error)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    for (int i = 0; i < DEPTH; i++) model_mem[i] = 64'd0;
    check_val("rst_ready", {63'd0, ready}, 64'd0);
    check_val("rst_wb_valid", {63'd0, wb_valid}, 64'd0);
    check_val("rst_wb_rw", {63'd0, wb_RegWrite}, 64'd0);
    check_val("rst_wb_data", wb_data, 64'd0);
    check_val("rst_mem_error", {63'd0, mem_error}, 64'd0);
  endtask

  // Count cycles of ready = 0 while a store + taken branch is held on the inputs.
  task automatic wait_clear(input string tag);
    int cnt = 0;
    int noisy = 0;
    valid_in = 1'b1; MemWrite = 1'b1; MemRead = 1'b0; ALU_result = 64'h10;
    Write_data = 64'hFFFF_0000_FFFF_0000; Branch = 1'b1; Zero = 1'b1;
    while (ready !== 1'b1 && cnt < DEPTH + 20) begin
      if (wb_valid !== 1'b0 || PCSrc !== 1'b0 || mem_error !== 1'b0) noisy++;
      @(posedge clk);
      #1;
      cnt++;
    end
    check_val({tag, "_len"}, 64'(cnt), 64'(DEPTH));
    check_val({tag, "_quiet"}, 64'(noisy), 64'd0);
    valid_in = 1'b0; MemWrite = 1'b0; Branch = 1'b0; Zero = 1'b0;
  endtask

  // Drive one instruction for a cycle; scoreboard gets the expected MEM/WB bundle.
  task automatic issue(input string tag, input logic vin, input logic mr, input logic mw,
                       input logic m2r, input logic rw, input logic br, input logic zr,
                       input logic [63:0] addr, input logic [63:0] wdata,
                       input logic [63:0] tgt, input logic [4:0] rdv);
    wb_t         e;
    wb_t         got;
    logic        bad;
    logic [AW-1:0] idx;
    logic [63:0] a;
    valid_in = vin; MemRead = mr; MemWrite = mw; MemtoReg = m2r; RegWrite = rw;
    Branch = br; Zero = zr; ALU_result = addr; Write_data = wdata; Target = tgt; rd = rdv;
    #1;
    check_val({tag, "_pcsrc"}, {63'd0, PCSrc}, {63'd0, vin & br & zr});
    check_val({tag, "_btgt"}, Branch_target, tgt);
    a    = addr;
    bad  = (mr | mw) && ((a[2:0] != 3'b000) || ((a >> (AW + 3)) != 64'd0));
    idx  = a[AW+2:3];
    e.v   = vin;
    e.rw  = vin & rw & ~bad;
    e.rd  = rdv;
    e.err = vin & bad;
    e.data = bad ? 64'd0 : (m2r ? model_mem[idx] : addr);
    sb_q.push_back(e);
    if (vin && mw && !bad) model_mem[idx] = wdata;
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      check_val({tag, "_sb_empty"}, 64'd1, 64'd0);
    end else begin
      got.v = wb_valid; got.rw = wb_RegWrite; got.rd = wb_rd; got.data = wb_data;
      got.err = mem_error;
      e = sb_q.pop_front();
      check_val({tag, "_valid"}, {63'd0, got.v}, {63'd0, e.v});
      check_val({tag, "_rw"}, {63'd0, got.rw}, {63'd0, e.rw});
      check_val({tag, "_err"}, {63'd0, got.err}, {63'd0, e.err});
      if (e.v) begin
        check_val({tag, "_rd"}, {59'd0, got.rd}, {59'd0, e.rd});
        check_val({tag, "_data"}, got.data, e.data);
      end
    end
  endtask

  initial begin
    // clear after reset, inputs held active
    do_reset();
    wait_clear("clear");
    issue("ld0", 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 64'h0, 64'd0, 64'd0, 5'd1);
    issue("ld8", 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 64'h8, 64'd0, 64'd0, 5'd2);
    issue("ldtop", 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 64'((DEPTH-1)*8), 64'd0, 64'd0, 5'd3);
    issue("ld10", 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 64'h10, 64'd0, 64'd0, 5'd4);
    check_val("ld10_zero", wb_data, 64'd0);

    // store then load next cycle
    issue("sd40", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 64'h40, 64'h0123456789ABCDEF, 64'd0, 5'd0);
    issue("ld40", 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 64'h40, 64'd0, 64'd0, 5'd9);
    check_val("ld40_lit", wb_data, 64'h0123456789ABCDEF);

    // branch resolution
    issue("br_taken", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 64'd0, 64'd0, 64'h100, 5'd0);
    issue("br_nt", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 64'd0, 64'd0, 64'h100, 5'd0);
    issue("br_idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 64'd0, 64'd0, 64'h200, 5'd0);

    // bad accesses
    issue("sd41", 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 64'h41, 64'hDEAD, 64'd0, 5'd5);
    issue("ld40b", 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 64'h40, 64'd0, 64'd0, 5'd9);
    check_val("ld40b_lit", wb_data, 64'h0123456789ABCDEF);
    issue("ld_oob", 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 64'(DEPTH*8), 64'd0, 64'd0, 5'd6);
    issue("sd_hi", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 64'h8000_0000_0000_0040, 64'h77, 64'd0, 5'd0);
    issue("ld40c", 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 64'h40, 64'd0, 64'd0, 5'd9);

    // read+write together: store wins, load sees old data
    issue("sd80", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 64'h80, 64'h1111, 64'd0, 5'd0);
    issue("rw80", 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 64'h80, 64'h2222, 64'd0, 5'd10);
    check_val("rw80_old", wb_data, 64'h1111);
    issue("ld80", 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 64'h80, 64'd0, 64'd0, 5'd11);
    check_val("ld80_new", wb_data, 64'h2222);

    // ALU pass-through and idle cycle
    issue("alu5", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 64'd5, 64'd0, 64'd0, 5'd7);
    issue("idle", 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 64'h48, 64'h99, 64'd0, 5'd8);
    issue("ld48", 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 64'h48, 64'd0, 64'd0, 5'd12);

    // reset in the middle of the clear sweep
    do_reset();
    repeat (10) begin
      @(posedge clk);
      #1;
    end
    do_reset();
    wait_clear("reclear");
    issue("ld40_after", 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 64'h40, 64'd0, 64'd0, 5'd9);
    check_val("ld40_after_zero", wb_data, 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
